// File: rtl/player_hit.sv
// Player collision and life tracking: tests the three invader missiles against the
// player box each frame, reports the first hit, and runs the explosion/game-over sequence.
module player_hit #(
  parameter int PLAYER_Y       = 432,
  parameter int PLAYER_W       = 26,
  parameter int PLAYER_H       = 16,
  parameter int PROJ_W         = 3,
  parameter int PROJ_H         = 12,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       frame,
  input  logic [9:0] player_x,
  input  logic [9:0] m1_x,
  input  logic [9:0] m1_y,
  input  logic [9:0] m2_x,
  input  logic [9:0] m2_y,
  input  logic [9:0] m3_x,
  input  logic [9:0] m3_y,
  output logic [1:0] player_collision,
  output logic [1:0] lives,
  output logic       exploding,
  output logic       game_over
);

  typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_t;

  state_t     state_q, state_d;
  logic [5:0] timer_q, timer_d;
  logic [1:0] lives_q, lives_d;
  logic [1:0] coll_q, coll_d;
  logic       exploding_q, exploding_d;
  logic       game_over_q, game_over_d;
  logic [2:0] overlap;
  logic [1:0] hit_idx;

  // Sums are widened to 11 bits so boxes near column/row 1023 never wrap.
  function automatic logic hit_test(input logic [9:0] px, input logic [9:0] mx,
                                    input logic [9:0] my);
    logic [10:0] px_w, mx_w, my_w;
    px_w = {1'b0, px};
    mx_w = {1'b0, mx};
    my_w = {1'b0, my};
    return (mx_w < px_w + 11'(PLAYER_W)) &&
           (mx_w + 11'(PROJ_W) > px_w) &&
           (my_w < 11'(PLAYER_Y + PLAYER_H)) &&
           (my_w + 11'(PROJ_H) > 11'(PLAYER_Y));
  endfunction

  always_comb begin
    overlap[0] = hit_test(player_x, m1_x, m1_y);
    overlap[1] = hit_test(player_x, m2_x, m2_y);
    overlap[2] = hit_test(player_x, m3_x, m3_y);
    if (overlap[0])      hit_idx = 2'd1;
    else if (overlap[1]) hit_idx = 2'd2;
    else if (overlap[2]) hit_idx = 2'd3;
    else                 hit_idx = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lives_d = lives_q;
    coll_d  = 2'd0;
    case (state_q)
      ALIVE: begin
        if (frame && hit_idx != 2'd0) begin
          coll_d  = hit_idx;
          timer_d = 6'(EXPLODE_FRAMES);
          state_d = HIT;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end
      end
      HIT: begin
        if (frame) begin
          timer_d = timer_q - 6'd1;
          if (timer_q == 6'd1) state_d = (lives_q == 2'd0) ? DEAD : ALIVE;
        end
      end
      default: state_d = DEAD;
    endcase
    exploding_d = (state_d == HIT);
    game_over_d = (state_d == DEAD);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ALIVE;
      timer_q     <= 6'd0;
      lives_q     <= 2'(LIVES);
      coll_q      <= 2'd0;
      exploding_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lives_q     <= lives_d;
      coll_q      <= coll_d;
      exploding_q <= exploding_d;
      game_over_q <= game_over_d;
    end
  end

  assign player_collision = coll_q;
  assign lives            = lives_q;
  assign exploding        = exploding_q;
  assign game_over        = game_over_q;

endmodule

// File: tb/tb_player_hit.sv
// Self-checking bench for player_hit: directed edge cases followed by randomized frames,
// all compared against a frame-level game model.
module tb_player_hit;

  localparam int PLAYER_Y       = 432;
  localparam int PLAYER_W       = 26;
  localparam int PLAYER_H       = 16;
  localparam int PROJ_W         = 3;
  localparam int PROJ_H         = 12;
  localparam int LIVES          = 3;
  localparam int EXPLODE_FRAMES = 60;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       frame = 1'b0;
  logic [9:0] px = '0;
  logic [9:0] m1x = '0, m1y = '0, m2x = '0, m2y = '0, m3x = '0, m3y = '0;
  logic [1:0] player_collision, lives;
  logic       exploding, game_over;

  int checks = 0;
  int passes = 0;

  // Model: 0 = alive, 1 = exploding, 2 = dead.
  int m_mode, m_lives, m_left, m_coll;

  player_hit #(
    .PLAYER_Y(PLAYER_Y), .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H),
    .PROJ_W(PROJ_W), .PROJ_H(PROJ_H), .LIVES(LIVES), .EXPLODE_FRAMES(EXPLODE_FRAMES)
  ) dut (
    .clk(clk), .arst(arst), .frame(frame), .player_x(px),
    .m1_x(m1x), .m1_y(m1y), .m2_x(m2x), .m2_y(m2y), .m3_x(m3x), .m3_y(m3y),
    .player_collision(player_collision), .lives(lives),
    .exploding(exploding), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic bit ov(input int p, input int mx, input int my);
    return (mx < p + PLAYER_W) && (mx + PROJ_W > p) &&
           (my < PLAYER_Y + PLAYER_H) && (my + PROJ_H > PLAYER_Y);
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input int exp_coll);
    check({tag, ".collision"}, 10'(player_collision), 10'(exp_coll));
    check({tag, ".lives"},     10'(lives),            10'(m_lives));
    check({tag, ".exploding"}, 10'(exploding),        10'(m_mode == 1));
    check({tag, ".game_over"}, 10'(game_over),        10'(m_mode == 2));
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 arst = 1'b1;
    frame = 1'b0;
    #1;
    m_mode = 0; m_lives = LIVES; m_left = 0;
    check({tag, ".rst_collision"}, 10'(player_collision), 10'd0);
    check({tag, ".rst_lives"},     10'(lives),            10'(LIVES));
    check({tag, ".rst_exploding"}, 10'(exploding),        10'd0);
    check({tag, ".rst_game_over"}, 10'(game_over),        10'd0);
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic model_frame();
    int idx;
    m_coll = 0;
    if (m_mode == 0) begin
      idx = 0;
      if (ov(px, m1x, m1y))      idx = 1;
      else if (ov(px, m2x, m2y)) idx = 2;
      else if (ov(px, m3x, m3y)) idx = 3;
      if (idx != 0) begin
        m_coll = idx;
        if (m_lives > 0) m_lives--;
        m_mode = 1;
        m_left = EXPLODE_FRAMES;
      end
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = (m_lives == 0) ? 2 : 0;
    end
  endtask

  // One frame pulse with current inputs; then junk inputs in a non-frame cycle.
  task automatic do_frame(input string tag);
    logic [9:0] sx, s1x, s1y;
    sx = px; s1x = m1x; s1y = m1y;
    @(negedge clk);
    frame = 1'b1;
    model_frame();
    @(negedge clk);
    frame = 1'b0;
    check_all(tag, m_coll);
    m1x = px + 10'd5;
    m1y = 10'(PLAYER_Y);
    @(negedge clk);
    check({tag, ".pulse_end"}, 10'(player_collision), 10'd0);
    px = sx; m1x = s1x; m1y = s1y;
  endtask

  task automatic set_m(input int x1, input int y1, input int x2, input int y2,
                       input int x3, input int y3);
    m1x = 10'(x1); m1y = 10'(y1);
    m2x = 10'(x2); m2y = 10'(y2);
    m3x = 10'(x3); m3y = 10'(y3);
  endtask

  function automatic int near_or_far(input int center, input int span, input int lo);
    int v;
    if ($urandom_range(0, 9) < 4) v = center + $urandom_range(0, span) - lo;
    else v = $urandom_range(0, 1023);
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  initial begin
    apply_reset("reset");

    px = 10'd300;
    set_m(0, 0, 310, 430, 0, 0);
    do_frame("basic_hit");
    check("basic_hit.lives_const", 10'(lives), 10'd2);

    apply_reset("h_edge");
    px = 10'd300;
    set_m(326, 436, 0, 0, 0, 0); do_frame("h_right_miss");
    set_m(325, 436, 0, 0, 0, 0); do_frame("h_right_hit");
    apply_reset("h_edge2");
    set_m(297, 436, 0, 0, 0, 0); do_frame("h_left_miss");
    set_m(298, 436, 0, 0, 0, 0); do_frame("h_left_hit");

    apply_reset("v_edge");
    set_m(310, 420, 0, 0, 0, 0); do_frame("v_top_miss");
    set_m(310, 421, 0, 0, 0, 0); do_frame("v_top_hit");
    apply_reset("v_edge2");
    set_m(310, 448, 0, 0, 0, 0); do_frame("v_bot_miss");
    set_m(310, 447, 0, 0, 0, 0); do_frame("v_bot_hit");

    apply_reset("simul");
    set_m(305, 430, 310, 430, 315, 440);
    do_frame("simul_hit");
    check("simul.collision_const", 10'(player_collision), 10'd0);
    for (int i = 0; i < EXPLODE_FRAMES; i++) do_frame("invuln1");
    do_frame("rehit2");
    for (int i = 0; i < EXPLODE_FRAMES; i++) do_frame("invuln2");
    do_frame("rehit3");
    for (int i = 0; i < EXPLODE_FRAMES; i++) do_frame("invuln3");
    check("dead.game_over_const", 10'(game_over), 10'd1);
    for (int i = 0; i < 5; i++) do_frame("dead_hold");

    apply_reset("mid");
    set_m(310, 436, 0, 0, 0, 0);
    do_frame("mid_hit");
    for (int i = 0; i < EXPLODE_FRAMES / 2; i++) do_frame("mid_count");
    apply_reset("mid_reset");

    for (int i = 0; i < 400; i++) begin
      px  = 10'($urandom_range(0, 1023));
      m1x = 10'(near_or_far(px, 40, 10)); m1y = 10'(near_or_far(PLAYER_Y, 40, 20));
      m2x = 10'(near_or_far(px, 40, 10)); m2y = 10'(near_or_far(PLAYER_Y, 40, 20));
      m3x = 10'(near_or_far(px, 40, 10)); m3y = 10'(near_or_far(PLAYER_Y, 40, 20));
      if (m_mode == 2 || $urandom_range(0, 99) == 0) apply_reset("rand_reset");
      do_frame("random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
